// File: rtl/mem_seq_pkg.sv
// Shared types and default widths for mem_seq_master and the memory it drives.
package mem_seq_pkg;

    localparam int ADDR_W_DEF = 8;
    localparam int DATA_W_DEF = 16;

    typedef enum logic [1:0] {
        OP_NOP   = 2'd0,
        OP_WRITE = 2'd1,
        OP_READ  = 2'd2,
        OP_RSVD  = 2'd3
    } op_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_WR,
        ST_RD_ISSUE,
        ST_RD_WAIT,
        ST_RD_OUT
    } state_t;

endpackage

// File: rtl/mem_seq_master.sv
// Command-driven sequencer that fills and burst-reads the single-port memory,
// streaming read words back on a valid/ready port with a last-word flag.
module mem_seq_master
    import mem_seq_pkg::*;
#(
    parameter int ADDR_W       = ADDR_W_DEF,
    parameter int DATA_W       = DATA_W_DEF,
    parameter int LEN_W        = 9,
    parameter int READ_LATENCY = 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic [1:0]        cmd_op,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [LEN_W-1:0]  cmd_len,
    input  logic [DATA_W-1:0] cmd_data,
    output logic              rd_valid,
    input  logic              rd_ready,
    output logic [DATA_W-1:0] rd_data,
    output logic              rd_last,
    output logic              done,
    output logic              busy,
    output logic [ADDR_W-1:0] mem_address,
    output logic [DATA_W-1:0] mem_data_in,
    output logic              mem_write_enable,
    output logic              mem_read_enable,
    input  logic [DATA_W-1:0] mem_data_out
);

    localparam int LAT_W = (READ_LATENCY > 1) ? $clog2(READ_LATENCY) : 1;
    localparam logic [LAT_W-1:0] LAT_LAST = LAT_W'(READ_LATENCY - 1);

    state_t            r_state;
    state_t            w_next;
    logic [ADDR_W-1:0] r_addr;
    logic [LEN_W-1:0]  r_rem;
    logic [DATA_W-1:0] r_wdata;
    logic [DATA_W-1:0] r_rd_data;
    logic [LAT_W-1:0]  r_lat;
    logic              r_done;
    op_t               w_op;
    logic              w_launch;
    logic              w_step;
    logic              w_capture;
    logic              w_done_next;
    logic              w_last;

    assign w_op   = op_t'(cmd_op);
    assign w_last = (r_rem == LEN_W'(1));

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // The address is not advanced on the final word so mem_address keeps
    // showing the last location touched once the command finishes.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_addr    <= '0;
            r_rem     <= '0;
            r_wdata   <= '0;
            r_rd_data <= '0;
            r_lat     <= '0;
            r_done    <= 1'b0;
        end else begin
            r_done <= w_done_next;
            if (w_launch) begin
                r_addr <= cmd_addr;
                r_rem  <= cmd_len;
                if (w_op == OP_WRITE) begin
                    r_wdata <= cmd_data;
                end
            end
            if (w_step) begin
                r_addr <= r_addr + ADDR_W'(1);
                r_rem  <= r_rem - LEN_W'(1);
            end
            if (r_state == ST_RD_ISSUE) begin
                r_lat <= '0;
            end else if (r_state == ST_RD_WAIT && !w_capture) begin
                r_lat <= r_lat + LAT_W'(1);
            end
            if (w_capture) begin
                r_rd_data <= mem_data_out;
            end
        end
    end

    always_comb begin
        w_next           = r_state;
        w_launch         = 1'b0;
        w_step           = 1'b0;
        w_capture        = 1'b0;
        w_done_next      = 1'b0;
        cmd_ready        = 1'b0;
        busy             = 1'b0;
        done             = 1'b0;
        rd_valid         = 1'b0;
        rd_last          = 1'b0;
        rd_data          = '0;
        mem_address      = '0;
        mem_data_in      = '0;
        mem_write_enable = 1'b0;
        mem_read_enable  = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (cmd_valid) begin
                    if (w_op == OP_WRITE && cmd_len != '0) begin
                        w_next   = ST_WR;
                        w_launch = 1'b1;
                    end else if (w_op == OP_READ && cmd_len != '0) begin
                        w_next   = ST_RD_ISSUE;
                        w_launch = 1'b1;
                    end else begin
                        w_done_next = 1'b1;
                    end
                end
            end
            ST_WR: begin
                if (w_last) begin
                    w_next      = ST_IDLE;
                    w_done_next = 1'b1;
                end else begin
                    w_step = 1'b1;
                end
            end
            ST_RD_ISSUE: w_next = ST_RD_WAIT;
            ST_RD_WAIT: begin
                if (r_lat == LAT_LAST) begin
                    w_capture = 1'b1;
                    w_next    = ST_RD_OUT;
                end
            end
            ST_RD_OUT: begin
                if (rd_ready) begin
                    if (w_last) begin
                        w_next      = ST_IDLE;
                        w_done_next = 1'b1;
                    end else begin
                        w_step = 1'b1;
                        w_next = ST_RD_ISSUE;
                    end
                end
            end
            default: w_next = ST_IDLE;
        endcase

        // Every output is forced low for as long as reset is held.
        if (!reset) begin
            cmd_ready        = (r_state == ST_IDLE);
            busy             = (r_state != ST_IDLE);
            done             = r_done;
            rd_valid         = (r_state == ST_RD_OUT);
            rd_last          = (r_state == ST_RD_OUT) && w_last;
            rd_data          = r_rd_data;
            mem_address      = r_addr;
            mem_data_in      = r_wdata;
            mem_write_enable = (r_state == ST_WR);
            mem_read_enable  = (r_state == ST_RD_ISSUE);
        end
    end

endmodule

// File: tb/tb_mem_seq_master.sv
// Directed bench for mem_seq_master: attaches a 1-cycle-latency memory and
// compares every cycle against a cycle-scheduled transaction model.
module tb_mem_seq_master;

    localparam int L = 1;

    logic        clk;
    logic        reset;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [1:0]  cmd_op;
    logic [7:0]  cmd_addr;
    logic [8:0]  cmd_len;
    logic [15:0] cmd_data;
    logic        rd_valid;
    logic        rd_ready;
    logic [15:0] rd_data;
    logic        rd_last;
    logic        done;
    logic        busy;
    logic [7:0]  mem_address;
    logic [15:0] mem_data_in;
    logic        mem_write_enable;
    logic        mem_read_enable;
    logic [15:0] mem_data_out;

    mem_seq_master #(.ADDR_W(8), .DATA_W(16), .LEN_W(9), .READ_LATENCY(L)) dut (
        .clk(clk), .reset(reset),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
        .cmd_addr(cmd_addr), .cmd_len(cmd_len), .cmd_data(cmd_data),
        .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data), .rd_last(rd_last),
        .done(done), .busy(busy),
        .mem_address(mem_address), .mem_data_in(mem_data_in),
        .mem_write_enable(mem_write_enable), .mem_read_enable(mem_read_enable),
        .mem_data_out(mem_data_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int compared = 0;
    int mismatched = 0;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0h, expected %0h (time %0t)", name, actual, expected, $time);
        end
    endtask

    // Attached memory: registered read, one cycle from read_enable to data_out
    logic [15:0] memArr [256];
    initial begin
        for (int i = 0; i < 256; i++) memArr[i] = 16'h0000;
        mem_data_out = 16'h0000;
    end
    always @(posedge clk) begin
        if (mem_write_enable) memArr[mem_address] <= mem_data_in;
        if (mem_read_enable) mem_data_out <= memArr[mem_address];
    end

    // Transaction model: each command becomes a schedule of cycle numbers
    int          cyc = 0;
    bit          mValid = 0;
    int          freeAt, doneAt;
    bit          wrOn, rdOn;
    int          wrFirst, wrCount, rdIssue, rdLeft;
    logic [7:0]  wrBase, rdAddr, lastAddr, idx;
    logic [15:0] wrData, rdWord, lastDin;
    logic [15:0] refMem [256];
    initial for (int i = 0; i < 256; i++) refMem[i] = 16'h0000;

    always @(posedge clk) begin
        int n;
        n = cyc;
        if (reset) begin
            mValid = 1; freeAt = n + 1; doneAt = -1;
            wrOn = 0; rdOn = 0; lastAddr = 8'h00; lastDin = 16'h0000;
        end else if (mValid) begin
            if (wrOn && n >= wrFirst && n < wrFirst + wrCount) begin
                idx = wrBase + 8'(n - wrFirst);
                refMem[idx] = wrData;
                lastAddr = idx;
                lastDin = wrData;
            end
            if (rdOn && n == rdIssue) begin
                rdWord = refMem[rdAddr];
                lastAddr = rdAddr;
            end
            if (rdOn && n >= rdIssue + L + 1 && rd_ready) begin
                if (rdLeft == 1) begin
                    rdOn = 0; doneAt = n + 1; freeAt = n + 1;
                end else begin
                    rdAddr = rdAddr + 8'd1; rdLeft = rdLeft - 1; rdIssue = n + 1;
                end
            end
            if (n >= freeAt && cmd_valid) begin
                if (cmd_op == 2'd1 && cmd_len != 0) begin
                    wrOn = 1; wrFirst = n + 1; wrCount = int'(cmd_len);
                    wrBase = cmd_addr; wrData = cmd_data;
                    freeAt = n + 1 + int'(cmd_len); doneAt = freeAt;
                end else if (cmd_op == 2'd2 && cmd_len != 0) begin
                    rdOn = 1; rdAddr = cmd_addr; rdLeft = int'(cmd_len);
                    rdIssue = n + 1; freeAt = 32'h7fffffff;
                end else begin
                    doneAt = n + 1;
                end
            end
        end
        cyc = cyc + 1;
    end

    logic        eWe, eRe, eRv, eLast, eDone, eReady;
    logic [7:0]  eAddr;
    logic [15:0] eDin;

    always @(negedge clk) begin
        if (mValid) begin
            if (reset) begin
                eWe = 0; eRe = 0; eRv = 0; eLast = 0; eDone = 0; eReady = 0;
                eAddr = 8'h00; eDin = 16'h0000;
                checkOutput("rstRdData", rd_data, 0);
                checkOutput("rstBusy", busy, 0);
            end else begin
                eWe    = wrOn && cyc >= wrFirst && cyc < wrFirst + wrCount;
                eRe    = rdOn && cyc == rdIssue;
                eAddr  = eWe ? wrBase + 8'(cyc - wrFirst) : (eRe ? rdAddr : lastAddr);
                eDin   = eWe ? wrData : lastDin;
                eRv    = rdOn && cyc >= rdIssue + L + 1;
                eLast  = eRv && rdLeft == 1;
                eDone  = (cyc == doneAt);
                eReady = (cyc >= freeAt);
                checkOutput("busy", busy, !eReady);
                if (eRv) checkOutput("rdData", rd_data, eRd());
            end
            checkOutput("memWe", mem_write_enable, eWe);
            checkOutput("memRe", mem_read_enable, eRe);
            checkOutput("memAddr", mem_address, eAddr);
            checkOutput("memDin", mem_data_in, eDin);
            checkOutput("rdValid", rd_valid, eRv);
            checkOutput("rdLast", rd_last, eLast);
            checkOutput("done", done, eDone);
            checkOutput("cmdReady", cmd_ready, eReady);
        end
    end

    function automatic logic [15:0] eRd();
        return rdWord;
    endfunction

    // Observed traffic, used by the hand-computed checks
    logic [15:0] wordQ [$];
    bit          lastQ [$];
    logic [7:0]  wrAddrQ [$];
    int          doneCount = 0;
    int          enCount = 0;
    int          lastDoneCyc = -1;

    always @(negedge clk) begin
        if (!reset) begin
            if (rd_valid && rd_ready) begin
                wordQ.push_back(rd_data);
                lastQ.push_back(rd_last);
            end
            if (mem_write_enable) wrAddrQ.push_back(mem_address);
            if (mem_write_enable || mem_read_enable) enCount++;
            if (done) begin
                doneCount++;
                lastDoneCyc = cyc;
            end
        end
    end

    task automatic applyStimulus(input logic [1:0] op, input logic [7:0] addr, input logic [8:0] len,
                                 input logic [15:0] data, input bit keepValid, output int acceptCyc);
        bit accepted;
        accepted = 0;
        acceptCyc = -1;
        cmd_valid = 1'b1; cmd_op = op; cmd_addr = addr; cmd_len = len; cmd_data = data;
        for (int i = 0; i < 500 && !accepted; i++) begin
            @(negedge clk);
            if (cmd_ready) begin
                accepted = 1;
                acceptCyc = cyc;
            end
            @(posedge clk);
            #1;
        end
        if (!keepValid) cmd_valid = 1'b0;
        if (!accepted) checkOutput("cmdAcceptTimeout", 0, 1);
    endtask

    task automatic waitDone(input int limit);
        bit seen;
        seen = 0;
        for (int i = 0; i < limit && !seen; i++) begin
            @(negedge clk);
            if (done) seen = 1;
        end
        if (!seen) checkOutput("doneTimeout", 0, 1);
        @(posedge clk);
        #1;
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int acc, accW, accR, dc0, en0;
        reset = 1'b1; cmd_valid = 1'b0; cmd_op = 2'd0; cmd_addr = 8'h00;
        cmd_len = 9'd0; cmd_data = 16'h0000; rd_ready = 1'b1;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        checkOutput("postResetReady", cmd_ready, 1);
        checkOutput("postResetBusy", busy, 0);
        @(posedge clk); #1;

        $display("[TB] reset during fill");
        wrAddrQ.delete();
        dc0 = doneCount;
        applyStimulus(2'd1, 8'h10, 9'd8, 16'h5555, 0, acc);
        repeat (3) @(posedge clk);
        #1 reset = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        checkOutput("midFillReady", cmd_ready, 1);
        repeat (3) @(negedge clk);
        checkOutput("midFillWrites", wrAddrQ.size(), 3);
        checkOutput("midFillMem12", memArr[8'h12], 16'h5555);
        checkOutput("midFillMem13", memArr[8'h13], 16'h0000);
        checkOutput("midFillNoDone", doneCount, dc0);
        @(posedge clk); #1;

        $display("[TB] single word round trip");
        wrAddrQ.delete();
        applyStimulus(2'd1, 8'h00, 9'd1, 16'h1234, 0, acc);
        waitDone(20);
        checkOutput("rtWrCount", wrAddrQ.size(), 1);
        checkOutput("rtMem0", memArr[8'h00], 16'h1234);
        wordQ.delete(); lastQ.delete();
        applyStimulus(2'd2, 8'h00, 9'd1, 16'h0000, 0, acc);
        waitDone(20);
        checkOutput("rtWords", wordQ.size(), 1);
        if (wordQ.size() == 1) begin
            checkOutput("rtData", wordQ[0], 16'h1234);
            checkOutput("rtLast", lastQ[0], 1);
        end

        $display("[TB] address wrap");
        wrAddrQ.delete();
        applyStimulus(2'd1, 8'hFE, 9'd4, 16'hBEEF, 0, acc);
        waitDone(20);
        checkOutput("wrapWrCount", wrAddrQ.size(), 4);
        if (wrAddrQ.size() == 4) begin
            checkOutput("wrapA0", wrAddrQ[0], 8'hFE);
            checkOutput("wrapA1", wrAddrQ[1], 8'hFF);
            checkOutput("wrapA2", wrAddrQ[2], 8'h00);
            checkOutput("wrapA3", wrAddrQ[3], 8'h01);
        end
        wordQ.delete(); lastQ.delete();
        applyStimulus(2'd2, 8'hFE, 9'd4, 16'h0000, 0, acc);
        waitDone(40);
        checkOutput("wrapWords", wordQ.size(), 4);
        foreach (wordQ[i]) begin
            checkOutput("wrapData", wordQ[i], 16'hBEEF);
            checkOutput("wrapLast", lastQ[i], (i == 3));
        end

        $display("[TB] degenerate commands");
        en0 = enCount;
        applyStimulus(2'd1, 8'h20, 9'd0, 16'hFFFF, 0, acc);
        @(negedge clk);
        checkOutput("len0Done", done, 1);
        @(posedge clk); #1;
        applyStimulus(2'd3, 8'h20, 9'd5, 16'hFFFF, 0, acc);
        @(negedge clk);
        checkOutput("rsvdDone", done, 1);
        @(posedge clk); #1;
        applyStimulus(2'd0, 8'h20, 9'd5, 16'hFFFF, 0, acc);
        @(negedge clk);
        checkOutput("nopDone", done, 1);
        @(posedge clk); #1;
        checkOutput("degenEnables", enCount - en0, 0);

        $display("[TB] read backpressure");
        for (int i = 0; i < 4; i++) begin
            applyStimulus(2'd1, 8'(i), 9'd1, 16'hA000 + 16'(i), 0, acc);
            waitDone(20);
        end
        wordQ.delete(); lastQ.delete();
        applyStimulus(2'd2, 8'h00, 9'd4, 16'h0000, 0, acc);
        repeat (3) @(posedge clk);
        #1 rd_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (i >= 2) begin
                checkOutput("stallValid", rd_valid, 1);
                checkOutput("stallData", rd_data, 16'hA001);
                checkOutput("stallNoRe", mem_read_enable, 0);
                checkOutput("stallNotLast", rd_last, 0);
            end
        end
        @(posedge clk);
        #1 rd_ready = 1'b1;
        waitDone(60);
        checkOutput("bpWords", wordQ.size(), 4);
        foreach (wordQ[i]) begin
            checkOutput("bpData", wordQ[i], 16'hA000 + 16'(i));
            checkOutput("bpLast", lastQ[i], (i == 3));
        end

        $display("[TB] back-to-back commands");
        wordQ.delete(); lastQ.delete();
        applyStimulus(2'd1, 8'h40, 9'd2, 16'h7777, 1, accW);
        applyStimulus(2'd2, 8'h40, 9'd2, 16'h0000, 0, accR);
        checkOutput("b2bAcceptInDone", accR, lastDoneCyc);
        checkOutput("b2bGap", accR - accW, 3);
        waitDone(40);
        checkOutput("b2bWords", wordQ.size(), 2);
        foreach (wordQ[i]) checkOutput("b2bData", wordQ[i], 16'h7777);

        repeat (2) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
